// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: WIDTH bits split into STAGES chunks, one chunk per stage.
// Define CLA_PIPE_OVF_EN to add a registered signed-overflow output (ovf).
module cla_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef CLA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CHUNK = WIDTH / STAGES;

    // Flattened lookahead: each carry is a sum of generate terms gated by the
    // product of the propagates above them, so no carry depends on another.
    function automatic logic [CHUNK:0] cla_carries(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             cin
    );
        logic [CHUNK-1:0] g;
        logic [CHUNK-1:0] p;
        logic [CHUNK:0]   c;
        logic             acc;
        logic             pp;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (g[j] & pp);
                pp  = pp & p[j];
            end
            acc      = acc | (cin & pp);
            c[i + 1] = acc;
        end
        return c;
    endfunction

    logic             adv;

    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             v_q   [STAGES];

    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic             c_d   [STAGES];
    logic             v_d   [STAGES];

    logic [WIDTH-1:0] a_src [STAGES];
    logic [WIDTH-1:0] b_src [STAGES];
    logic [WIDTH-1:0] s_src [STAGES];
    logic             c_src [STAGES];
    logic             v_src [STAGES];

    logic [CHUNK:0]   carries_w [STAGES];

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign s         = s_q[STAGES-1];
    assign co        = c_q[STAGES-1];
    assign out_valid = v_q[STAGES-1];

    // Stage 0 is fed from the ports; every later stage from its predecessor.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_src
            if (gi == 0) begin : g_first
                assign a_src[gi] = a;
                assign b_src[gi] = b;
                assign s_src[gi] = '0;
                assign c_src[gi] = ci;
                assign v_src[gi] = in_valid;
            end else begin : g_next
                assign a_src[gi] = a_q[gi-1];
                assign b_src[gi] = b_q[gi-1];
                assign s_src[gi] = s_q[gi-1];
                assign c_src[gi] = c_q[gi-1];
                assign v_src[gi] = v_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]       = a_src[k];
            b_d[k]       = b_src[k];
            s_d[k]       = s_src[k];
            v_d[k]       = v_src[k];
            carries_w[k] = cla_carries(a_src[k][k*CHUNK +: CHUNK],
                                       b_src[k][k*CHUNK +: CHUNK],
                                       c_src[k]);
            s_d[k][k*CHUNK +: CHUNK] = a_src[k][k*CHUNK +: CHUNK]
                                     ^ b_src[k][k*CHUNK +: CHUNK]
                                     ^ carries_w[k][CHUNK-1:0];
            c_d[k]       = carries_w[k][CHUNK];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
                v_q[k] <= v_d[k];
            end
        end
    end

`ifdef CLA_PIPE_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // Carry into the MSB versus carry out of it, both from the last chunk.
    assign ovf_d = carries_w[STAGES-1][CHUNK] ^ carries_w[STAGES-1][CHUNK-1];
    assign ovf   = ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder: default 32/4 instance plus a 16/1 instance.
// Overflow checks are included when CLA_PIPE_OVF_EN is defined.
module tb_cla_pipe_adder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        co;

    logic        u_in_valid;
    logic        u_in_ready;
    logic [15:0] u_a;
    logic [15:0] u_b;
    logic        u_ci;
    logic        u_out_valid;
    logic        u_out_ready;
    logic [15:0] u_s;
    logic        u_co;

`ifdef CLA_PIPE_OVF_EN
    logic        ovf;
    logic        u_ovf;
`endif

    int n_checks;
    int n_fail;
    int lat;
    int stale;

    cla_pipe_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co)
`ifdef CLA_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    cla_pipe_adder #(.WIDTH(16), .STAGES(1)) dut_narrow (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (u_in_valid),
        .in_ready  (u_in_ready),
        .a         (u_a),
        .b         (u_b),
        .ci        (u_ci),
        .out_valid (u_out_valid),
        .out_ready (u_out_ready),
        .s         (u_s),
        .co        (u_co)
`ifdef CLA_PIPE_OVF_EN
        ,
        .ovf       (u_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic vc);
        a        = va;
        b        = vb;
        ci       = vc;
        in_valid = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        ci          = 1'b0;
        out_ready   = 1'b1;
        u_in_valid  = 1'b0;
        u_a         = '0;
        u_b         = '0;
        u_ci        = 1'b0;
        u_out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_s", s, 0);
        check("rst_co", co, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_u_out_valid", u_out_valid, 0);
        reset = 1'b0;
        tick();

        // Single op, measure latency counting the accept edge as cycle 1.
        drive(32'hABABBABA, 32'h12345678, 1'b1);
        check("lat_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("lat_cycles", lat, 4);
        check("lat_s", s, 32'hBDE01133);
        check("lat_co", co, 0);
        tick();
        check("lat_drained", out_valid, 0);

        // Back-to-back accepts, results on consecutive cycles in order.
        drive(32'h0000FFFF, 32'hFFFF0000, 1'b0);
        tick();
        drive(32'hFEDCBA98, 32'h89ABCDEF, 1'b0);
        tick();
        drive(32'hFFFFFFFF, 32'h00000000, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        check("b2b0_valid", out_valid, 1);
        check("b2b0_s", s, 32'hFFFFFFFF);
        check("b2b0_co", co, 0);
        tick();
        check("b2b1_valid", out_valid, 1);
        check("b2b1_s", s, 32'h88888887);
        check("b2b1_co", co, 1);
        tick();
        check("b2b2_valid", out_valid, 1);
        check("b2b2_s", s, 32'h00000000);
        check("b2b2_co", co, 1);
        tick();
        check("b2b_end_valid", out_valid, 0);

        // Stall with a result at the output and a second one behind it.
        drive(32'h00000001, 32'h00000002, 1'b0);
        tick();
        drive(32'h00000010, 32'h00000020, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("stall_first_valid", out_valid, 1);
        check("stall_first_s", s, 32'h3);
        out_ready = 1'b0;
        #1;
        check("stall_in_ready", in_ready, 0);
        tick();
        tick();
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_s", s, 32'h3);
        check("stall_hold_co", co, 0);
        check("stall_hold_in_ready", in_ready, 0);
        out_ready = 1'b1;
        #1;
        check("stall_release_in_ready", in_ready, 1);
        tick();
        check("stall_next_valid", out_valid, 1);
        check("stall_next_s", s, 32'h30);
        tick();
        check("stall_no_dup", out_valid, 0);

        // Reset with two operations in flight, one stalled at the output.
        drive(32'hABABBABA, 32'h12345678, 1'b1);
        tick();
        drive(32'hFEDCBA98, 32'h89ABCDEF, 1'b0);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("prerst_valid", out_valid, 1);
        check("prerst_s", s, 32'hBDE01133);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_s", s, 0);
        check("midrst_co", co, 0);
        #2;
        reset     = 1'b0;
        out_ready = 1'b1;
        stale     = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) stale++;
        end
        check("postrst_no_stale", stale, 0);
        drive(32'h00000001, 32'h00000001, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("postrst_valid", out_valid, 1);
        check("postrst_s", s, 32'h2);
        tick();

`ifdef CLA_PIPE_OVF_EN
        drive(32'h7FFFFFFF, 32'h00000001, 1'b0);
        tick();
        drive(32'hFEDCBA98, 32'h89ABCDEF, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("ovf0_s", s, 32'h80000000);
        check("ovf0_co", co, 0);
        check("ovf0_ovf", ovf, 1);
        tick();
        check("ovf1_s", s, 32'h88888887);
        check("ovf1_ovf", ovf, 0);
        tick();
`endif

        // Single-stage 16-bit instance.
        u_a        = 16'hA5A5;
        u_b        = 16'h5A5B;
        u_ci       = 1'b0;
        u_in_valid = 1'b1;
        tick();
        u_in_valid = 1'b0;
        check("n16_valid", u_out_valid, 1);
        check("n16_s", u_s, 16'h0000);
        check("n16_co", u_co, 1);
        tick();
        check("n16_drained", u_out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
